// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    RSRC_NONE = 2'd0,
    RSRC_RS   = 2'd1,
    RSRC_MEM  = 2'd2
  } redir_src_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Write-back redirect detection and target selection (purely combinational).
module fetch_redirect_sel
  import fetch_pkg::*;
(
  input  logic        i_jump,
  input  logic        i_jump_mem,
  input  logic        i_branch_z,
  input  logic        i_branch_n,
  input  logic        i_z,
  input  logic        i_n,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_data,
  output redir_src_e  o_src,
  output logic [31:0] o_target
);

  always_comb begin
    o_src = RSRC_NONE;
    if (i_jump_mem)
      o_src = RSRC_MEM;
    else if (i_jump | (i_branch_z & i_z) | (i_branch_n & i_n))
      o_src = RSRC_RS;
    o_target = (o_src == RSRC_MEM) ? i_data : i_rs;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM, one-entry hold buffer.
// Optional FETCH_PERF_EN adds fetch/redirect performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_INC   = 32'd1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_ready,
  output logic [31:0] pc_if,
  output logic [31:0] inst_if,
  output logic        inst_valid,
  input  logic        jump_wb,
  input  logic        jump_mem_wb,
  input  logic        branch_z_wb,
  input  logic        branch_n_wb,
  input  logic        z_wb,
  input  logic        n_wb,
  input  logic [31:0] rs_wb,
  input  logic [31:0] data_wb
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt, r_req_pc;
  logic [31:0]  r_pc_if, r_inst_if, r_hold_pc, r_hold_inst;
  logic         r_inst_valid;
  redir_src_e   w_src;
  logic [31:0]  w_target;
  logic         w_redirect, w_req_fire, w_present, w_hold_ld, w_hold_exit, w_show_hold;

  fetch_redirect_sel u_sel (
    .i_jump     (jump_wb),
    .i_jump_mem (jump_mem_wb),
    .i_branch_z (branch_z_wb),
    .i_branch_n (branch_n_wb),
    .i_z        (z_wb),
    .i_n        (n_wb),
    .i_rs       (rs_wb),
    .i_data     (data_wb),
    .o_src      (w_src),
    .o_target   (w_target)
  );

  assign w_redirect = (w_src != RSRC_NONE);
  // A redirect cancels the request, and nothing new issues until the presented word is taken.
  assign imem_req_valid = (r_state == REQ) & ~w_redirect & ~(r_inst_valid & ~id_ready);
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign imem_addr      = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_present   = 1'b0;
    w_hold_ld   = 1'b0;
    w_hold_exit = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_redirect)      w_pc_nxt    = w_target;
        else if (w_req_fire) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          if (id_ready) begin
            w_present   = 1'b1;
            w_pc_nxt    = r_pc + PC_INC;
            w_state_nxt = REQ;
          end else begin
            w_hold_ld   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      DRAIN: begin
        if (w_redirect)     w_pc_nxt    = w_target;
        if (imem_rsp_valid) w_state_nxt = REQ;
      end
      HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_hold_exit = 1'b1;
          w_state_nxt = REQ;
        end else if (id_ready) begin
          w_pc_nxt    = r_pc + PC_INC;
          w_hold_exit = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_pc     <= RESET_PC;
      r_hold_pc    <= RESET_PC;
      r_hold_inst  <= NOP_WORD;
      r_pc_if      <= RESET_PC;
      r_inst_if    <= NOP_WORD;
      r_inst_valid <= 1'b0;
    end else begin
      if (w_req_fire) r_req_pc <= r_pc;
      if (w_hold_ld) begin
        r_hold_pc   <= r_req_pc;
        r_hold_inst <= imem_rsp_data;
      end
      if (w_present) begin
        r_pc_if      <= r_req_pc;
        r_inst_if    <= imem_rsp_data;
        r_inst_valid <= 1'b1;
      end else if (w_hold_exit) begin
        // Keep pc_if on the last held PC so it never steps backwards.
        r_pc_if      <= r_hold_pc;
        r_inst_if    <= NOP_WORD;
        r_inst_valid <= 1'b0;
      end else if (id_ready | w_redirect) begin
        r_inst_if    <= NOP_WORD;
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign w_show_hold = (r_state == HOLD);
  assign pc_if       = w_show_hold ? r_hold_pc : r_pc_if;
  assign inst_if     = w_redirect ? NOP_WORD : (w_show_hold ? r_hold_inst : r_inst_if);
  assign inst_valid  = ~w_redirect & (w_show_hold | r_inst_valid);

`ifdef FETCH_PERF_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= 32'd0;
      perf_redirect_cnt <= 32'd0;
    end else begin
      if (inst_valid & id_ready) perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (w_redirect)            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus a streaming run.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic [31:0] pc_if, inst_if;
  logic        inst_valid;
  logic        jump_wb, jump_mem_wb, branch_z_wb, branch_n_wb, z_wb, n_wb;
  logic [31:0] rs_wb, data_wb;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_ready(id_ready), .pc_if(pc_if), .inst_if(inst_if), .inst_valid(inst_valid),
    .jump_wb(jump_wb), .jump_mem_wb(jump_mem_wb), .branch_z_wb(branch_z_wb),
    .branch_n_wb(branch_n_wb), .z_wb(z_wb), .n_wb(n_wb), .rs_wb(rs_wb), .data_wb(data_wb)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  // ctl = {jump_mem_wb, jump_wb, branch_z_wb, branch_n_wb, z_wb, n_wb}
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rsv;
    logic [31:0] rdata;
    logic        idr;
    logic [5:0]  ctl;
    logic [31:0] rs;
    logic [31:0] dwb;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  localparam int NV = 49;
  vec_t tv[NV];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rsv,
                              input logic [31:0] rdata, input logic idr, input logic [5:0] ctl,
                              input logic [31:0] rs, input logic [31:0] dwb,
                              input logic erv, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rsv = rsv; v.rdata = rdata; v.idr = idr; v.ctl = ctl;
    v.rs = rs; v.dwb = dwb; v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv;
    v.e_pc = epc; v.e_inst = einst;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic rv, input logic [31:0] addr,
                          input logic iv, input logic [31:0] pc, input logic [31:0] inst);
    chk("req_valid",  idx, {31'd0, imem_req_valid}, {31'd0, rv});
    chk("imem_addr",  idx, imem_addr, addr);
    chk("inst_valid", idx, {31'd0, inst_valid}, {31'd0, iv});
    chk("pc_if",      idx, pc_if, pc);
    chk("inst_if",    idx, inst_if, inst);
  endtask

  initial begin
    bit          pend;
    logic [31:0] pend_addr, exp_pc;
    int          got, cyc;

    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b1; {jump_mem_wb, jump_wb, branch_z_wb, branch_n_wb, z_wb, n_wb} = '0;
    rs_wb = '0; data_wb = '0;

    // sequential fetch, memory returns addr+100
    tv[0]  = mk(1,1,0,0,  1,6'b000000,0,0, 0,0,0,0,0);
    tv[1]  = mk(1,1,0,0,  1,6'b000000,0,0, 1,0,0,0,0);
    tv[2]  = mk(1,1,1,100,1,6'b000000,0,0, 0,0,0,0,0);
    tv[3]  = mk(1,1,0,0,  1,6'b000000,0,0, 1,1,1,0,100);
    tv[4]  = mk(1,1,1,101,1,6'b000000,0,0, 0,1,0,0,0);
    tv[5]  = mk(1,1,0,0,  1,6'b000000,0,0, 1,2,1,1,101);
    tv[6]  = mk(1,1,1,102,1,6'b000000,0,0, 0,2,0,1,0);
    tv[7]  = mk(1,1,0,0,  1,6'b000000,0,0, 1,3,1,2,102);
    tv[8]  = mk(1,1,1,103,1,6'b000000,0,0, 0,3,0,2,0);
    tv[9]  = mk(1,1,0,0,  1,6'b000000,0,0, 1,4,1,3,103);
    tv[10] = mk(1,1,1,104,1,6'b000000,0,0, 0,4,0,3,0);
    tv[11] = mk(1,1,0,0,  1,6'b000000,0,0, 1,5,1,4,104);
    // PC 5 response under stall -> HOLD, then release
    tv[12] = mk(1,1,1,105,0,6'b000000,0,0, 0,5,0,4,0);
    tv[13] = mk(1,1,0,0,  0,6'b000000,0,0, 0,5,1,5,105);
    tv[14] = mk(1,1,0,0,  0,6'b000000,0,0, 0,5,1,5,105);
    tv[15] = mk(1,1,0,0,  1,6'b000000,0,0, 0,5,1,5,105);
    tv[16] = mk(1,1,0,0,  1,6'b000000,0,0, 1,6,0,5,0);
    // branch-on-zero in WAIT -> DRAIN, stale response dropped
    tv[17] = mk(1,1,0,0,  1,6'b001010,32'h40,0, 0,6,0,5,0);
    tv[18] = mk(1,1,1,106,1,6'b000000,0,0, 0,32'h40,0,5,0);
    tv[19] = mk(1,1,0,0,  1,6'b000000,0,0, 1,32'h40,0,5,0);
    tv[20] = mk(1,1,1,164,1,6'b000000,0,0, 0,32'h40,0,5,0);
    // jump_mem wins over jump, redirect in REQ squashes the presented word
    tv[21] = mk(1,1,0,0,  1,6'b110000,32'h20,32'h80, 0,32'h41,0,32'h40,0);
    tv[22] = mk(1,0,0,0,  1,6'b000000,0,0, 1,32'h80,0,32'h40,0);
    tv[23] = mk(1,1,0,0,  1,6'b000000,0,0, 1,32'h80,0,32'h40,0);
    // redirect coincident with response -> discard, go to FFFF_FFFF
    tv[24] = mk(1,1,1,228,1,6'b010000,32'hFFFF_FFFF,0, 0,32'h80,0,32'h40,0);
    tv[25] = mk(1,1,0,0,  1,6'b000000,0,0, 1,32'hFFFF_FFFF,0,32'h40,0);
    tv[26] = mk(1,1,1,32'h1234_5678,1,6'b000000,0,0, 0,32'hFFFF_FFFF,0,32'h40,0);
    tv[27] = mk(1,0,0,0,  1,6'b000000,0,0, 1,0,1,32'hFFFF_FFFF,32'h1234_5678);
    tv[28] = mk(1,1,0,0,  1,6'b000000,0,0, 1,0,0,32'hFFFF_FFFF,0);
    // unconsumed word blocks the next request
    tv[29] = mk(1,1,1,100,1,6'b000000,0,0, 0,0,0,32'hFFFF_FFFF,0);
    tv[30] = mk(1,1,0,0,  0,6'b000000,0,0, 0,1,1,0,100);
    tv[31] = mk(1,1,0,0,  0,6'b000000,0,0, 0,1,1,0,100);
    tv[32] = mk(1,1,0,0,  1,6'b000000,0,0, 1,1,1,0,100);
    tv[33] = mk(1,1,0,0,  1,6'b000000,0,0, 0,1,0,0,0);
    // branch-on-negative into DRAIN, second redirect in DRAIN wins
    tv[34] = mk(1,1,0,0,  1,6'b001101,32'h10,0, 0,1,0,0,0);
    tv[35] = mk(1,1,0,0,  1,6'b010000,32'h30,0, 0,32'h10,0,0,0);
    tv[36] = mk(1,1,1,101,1,6'b000000,0,0, 0,32'h30,0,0,0);
    tv[37] = mk(1,1,0,0,  1,6'b000100,32'h99,0, 1,32'h30,0,0,0);
    tv[38] = mk(1,1,1,148,1,6'b000000,0,0, 0,32'h30,0,0,0);
    tv[39] = mk(1,0,0,0,  1,6'b000000,0,0, 1,32'h31,1,32'h30,148);
    tv[40] = mk(1,1,0,0,  1,6'b000000,0,0, 1,32'h31,0,32'h30,0);
    // redirect while holding drops the buffer
    tv[41] = mk(1,1,1,149,0,6'b000000,0,0, 0,32'h31,0,32'h30,0);
    tv[42] = mk(1,1,0,0,  0,6'b010000,32'h50,0, 0,32'h31,0,32'h31,0);
    tv[43] = mk(1,1,0,0,  1,6'b000000,0,0, 1,32'h50,0,32'h31,0);
    // reset mid-WAIT, response during IDLE ignored
    tv[44] = mk(0,1,0,0,  1,6'b000000,0,0, 0,0,0,0,0);
    tv[45] = mk(1,1,1,32'hDEAD,1,6'b000000,0,0, 0,0,0,0,0);
    tv[46] = mk(1,1,0,0,  1,6'b000000,0,0, 1,0,0,0,0);
    tv[47] = mk(1,1,1,100,1,6'b000000,0,0, 0,0,0,0,0);
    tv[48] = mk(1,1,0,0,  1,6'b000000,0,0, 1,1,1,0,100);

    @(posedge clk); #1;
    chk_outs(-1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      rst_n = tv[i].rst; imem_req_ready = tv[i].rdy; imem_rsp_valid = tv[i].rsv;
      imem_rsp_data = tv[i].rdata; id_ready = tv[i].idr;
      {jump_mem_wb, jump_wb, branch_z_wb, branch_n_wb, z_wb, n_wb} = tv[i].ctl;
      rs_wb = tv[i].rs; data_wb = tv[i].dwb;
      #1;
      chk_outs(i, tv[i].e_rv, tv[i].e_addr, tv[i].e_iv, tv[i].e_pc, tv[i].e_inst);
    end

    // streaming run: request for PC 1 was accepted on the last vector
    pend = 1'b1; pend_addr = 32'd1; exp_pc = 32'd1; got = 0; cyc = 0;
    {jump_mem_wb, jump_wb, branch_z_wb, branch_n_wb, z_wb, n_wb} = '0;
    while (got < 8 && cyc < 40) begin
      @(posedge clk);
      imem_req_ready = 1'b1; id_ready = 1'b1;
      imem_rsp_valid = pend; imem_rsp_data = pend_addr + 32'd100;
      #1;
      if (inst_valid) begin
        chk("stream_pc",   got, pc_if, exp_pc);
        chk("stream_inst", got, inst_if, exp_pc + 32'd100);
        exp_pc = exp_pc + 32'd1;
        got++;
      end
      pend = imem_req_valid & imem_req_ready;
      if (pend) pend_addr = imem_addr;
      cyc++;
    end
    chk("stream_count",  0, got, 8);
    chk("stream_cycles", 0, cyc, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
